// File: rtl/aes_stream_checker.sv
// Latency-aligned result checker for pipelined block-cipher cores.
// Define AES_CHECK_CAPTURE_EN to build the first-failure capture registers.
module aes_stream_checker #(
  parameter int DATA_W  = 128,
  parameter int LATENCY = 21,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_expected,
  input  logic [DATA_W-1:0] in_mask,
  input  logic [DATA_W-1:0] dut_out,
  output logic              chk_valid,
  output logic              chk_pass,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              error,
  output logic              idle,
  output logic              cap_valid,
  output logic [DATA_W-1:0] cap_expected,
  output logic [DATA_W-1:0] cap_actual,
  output logic [CNT_W-1:0]  cap_index
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  exp_q [LATENCY];
  logic [DATA_W-1:0]  msk_q [LATENCY];
  logic               exit_valid;
  logic               exit_pass;

  assign exit_valid = vld_q[LATENCY-1];
  assign exit_pass  = (((dut_out ^ exp_q[LATENCY-1]) & msk_q[LATENCY-1]) == '0);
  assign idle       = ~|vld_q;

  // Only the valid bits need reset/clear; stale data is never compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_q[0] <= in_expected;
    msk_q[0] <= in_mask;
    for (int i = 1; i < LATENCY; i++) begin
      exp_q[i] <= exp_q[i-1];
      msk_q[i] <= msk_q[i-1];
    end
  end

  // chk_pass deliberately holds between comparisons, including across clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      error      <= 1'b0;
    end else if (clear) begin
      chk_valid  <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      error      <= 1'b0;
    end else if (exit_valid) begin
      chk_valid <= 1'b1;
      chk_pass  <= exit_pass;
      if (exit_pass) begin
        if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
      end else begin
        if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
        error <= 1'b1;
      end
    end else begin
      chk_valid <= 1'b0;
    end
  end

`ifdef AES_CHECK_CAPTURE_EN
  // The pre-increment counter sum is the 0-based index of the failing result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid    <= 1'b0;
      cap_expected <= '0;
      cap_actual   <= '0;
      cap_index    <= '0;
    end else if (clear) begin
      cap_valid    <= 1'b0;
      cap_expected <= '0;
      cap_actual   <= '0;
      cap_index    <= '0;
    end else if (exit_valid && !exit_pass && !cap_valid) begin
      cap_valid    <= 1'b1;
      cap_expected <= exp_q[LATENCY-1];
      cap_actual   <= dut_out;
      cap_index    <= pass_count + fail_count;
    end
  end
`else
  assign cap_valid    = 1'b0;
  assign cap_expected = '0;
  assign cap_actual   = '0;
  assign cap_index    = '0;
`endif

endmodule

// File: tb/tb_aes_stream_checker.sv
// Scoreboard bench for aes_stream_checker: a main instance (LATENCY=21) and
// a small saturation instance (LATENCY=3, CNT_W=2).
module tb_aes_stream_checker;

  localparam int LAT  = 21;
  localparam int LAT2 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         clear = 1'b0, in_valid = 1'b0;
  logic [127:0] in_expected = '0, in_mask = '0, dut_out = '0;
  logic         chk_valid, chk_pass, error, idle, cap_valid;
  logic [15:0]  pass_count, fail_count, cap_index;
  logic [127:0] cap_expected, cap_actual;

  logic         in_valid2 = 1'b0;
  logic [127:0] in_expected2 = '0, in_mask2 = '0, dut_out2 = '0;
  logic         chk_valid2, chk_pass2, error2, idle2, cap_valid2;
  logic [1:0]   pass_count2, fail_count2, cap_index2;
  logic [127:0] cap_expected2, cap_actual2;

  aes_stream_checker #(.DATA_W(128), .LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_expected(in_expected), .in_mask(in_mask), .dut_out(dut_out),
    .chk_valid(chk_valid), .chk_pass(chk_pass), .pass_count(pass_count),
    .fail_count(fail_count), .error(error), .idle(idle), .cap_valid(cap_valid),
    .cap_expected(cap_expected), .cap_actual(cap_actual), .cap_index(cap_index));

  aes_stream_checker #(.DATA_W(128), .LATENCY(LAT2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(in_valid2),
    .in_expected(in_expected2), .in_mask(in_mask2), .dut_out(dut_out2),
    .chk_valid(chk_valid2), .chk_pass(chk_pass2), .pass_count(pass_count2),
    .fail_count(fail_count2), .error(error2), .idle(idle2), .cap_valid(cap_valid2),
    .cap_expected(cap_expected2), .cap_actual(cap_actual2), .cap_index(cap_index2));

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int pulses = 0;
  int pulses2 = 0;
  int pulse_edges[$];
  bit sb[$];
  bit sb2[$];
  logic [127:0] sched [int];
  logic [127:0] sched2 [int];

  localparam logic [127:0] FIPS0 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] FIPS1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ONES  = '1;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Fake cores: scheduled value for the coming edge, junk otherwise.
  always @(negedge clk) begin
    if (sched.exists(edge_n + 1)) dut_out = sched[edge_n + 1];
    else dut_out = {$urandom, $urandom, $urandom, $urandom};
    if (sched2.exists(edge_n + 1)) dut_out2 = sched2[edge_n + 1];
    else dut_out2 = {$urandom, $urandom, $urandom, $urandom};
  end

  // Scoreboard pop on every reported comparison.
  always @(posedge clk) begin
    #1;
    if (chk_valid === 1'b1) begin
      bit e;
      pulses++;
      pulse_edges.push_back(edge_n);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_chk_valid at edge %0d", edge_n);
      end else begin
        e = sb.pop_front();
        if (chk_pass !== e) begin
          failures++;
          $display("[TB] FAIL chk_pass edge %0d got %b want %b", edge_n, chk_pass, e);
        end
      end
    end
    if (chk_valid2 === 1'b1) begin
      bit e2;
      pulses2++;
      checks++;
      if (sb2.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_chk_valid2 at edge %0d", edge_n);
      end else begin
        e2 = sb2.pop_front();
        if (chk_pass2 !== e2) begin
          failures++;
          $display("[TB] FAIL chk_pass2 got %b want %b", chk_pass2, e2);
        end
      end
    end
  end

  task automatic push(input logic [127:0] e, input logic [127:0] m, input logic [127:0] a);
    @(negedge clk);
    in_valid = 1'b1; in_expected = e; in_mask = m;
    sched[edge_n + 1 + LAT] = a;
    sb.push_back(((a ^ e) & m) == '0);
  endtask

  task automatic push2(input logic [127:0] e, input logic [127:0] a);
    @(negedge clk);
    in_valid2 = 1'b1; in_expected2 = e; in_mask2 = ONES;
    sched2[edge_n + 1 + LAT2] = a;
    sb2.push_back(a == e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_valid2 = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1; sb.delete();
    @(negedge clk);
    clear = 1'b0;
    pulses = 0; pulse_edges.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 10;
    if (chk_valid !== 1'b0)  begin failures++; $display("[TB] FAIL rst_chk_valid got %b want 0", chk_valid); end
    if (chk_pass !== 1'b0)   begin failures++; $display("[TB] FAIL rst_chk_pass got %b want 0", chk_pass); end
    if (pass_count !== 16'd0) begin failures++; $display("[TB] FAIL rst_pass_count got %0d want 0", pass_count); end
    if (fail_count !== 16'd0) begin failures++; $display("[TB] FAIL rst_fail_count got %0d want 0", fail_count); end
    if (error !== 1'b0)      begin failures++; $display("[TB] FAIL rst_error got %b want 0", error); end
    if (idle !== 1'b1)       begin failures++; $display("[TB] FAIL rst_idle got %b want 1", idle); end
    if (cap_valid !== 1'b0)  begin failures++; $display("[TB] FAIL rst_cap_valid got %b want 0", cap_valid); end
    if (cap_expected !== '0) begin failures++; $display("[TB] FAIL rst_cap_expected got %h want 0", cap_expected); end
    if (cap_actual !== '0)   begin failures++; $display("[TB] FAIL rst_cap_actual got %h want 0", cap_actual); end
    if (cap_index !== 16'd0) begin failures++; $display("[TB] FAIL rst_cap_index got %0d want 0", cap_index); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips_stream();
    int e0;
    push(FIPS0, ONES, FIPS0);
    e0 = edge_n + 1;
    push(FIPS1, ONES, FIPS1);
    checks++;
    if (idle !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_push got %b want 0", idle); end
    idle_cycles(LAT + 3);
    checks += 6;
    if (pulses !== 2) begin failures++; $display("[TB] FAIL fips_pulses got %0d want 2", pulses); end
    else if (pulse_edges[0] != e0 + LAT || pulse_edges[1] != e0 + LAT + 1) begin
      failures++;
      $display("[TB] FAIL fips_pulse_timing got %0d,%0d want %0d,%0d", pulse_edges[0], pulse_edges[1], e0 + LAT, e0 + LAT + 1);
    end
    if (pass_count !== 16'd2) begin failures++; $display("[TB] FAIL fips_pass_count got %0d want 2", pass_count); end
    if (fail_count !== 16'd0) begin failures++; $display("[TB] FAIL fips_fail_count got %0d want 0", fail_count); end
    if (error !== 1'b0) begin failures++; $display("[TB] FAIL fips_error got %b want 0", error); end
    if (idle !== 1'b1) begin failures++; $display("[TB] FAIL fips_idle got %b want 1", idle); end
    if (chk_pass !== 1'b1) begin failures++; $display("[TB] FAIL fips_chk_pass_hold got %b want 1", chk_pass); end
  endtask

  task automatic test_corruption();
    do_clear();
    push(FIPS0, ONES, FIPS0);
    push(FIPS1, ONES, FIPS1 ^ 128'd1);
    idle_cycles(LAT + 3);
    checks += 7;
    if (pass_count !== 16'd1) begin failures++; $display("[TB] FAIL corr_pass_count got %0d want 1", pass_count); end
    if (fail_count !== 16'd1) begin failures++; $display("[TB] FAIL corr_fail_count got %0d want 1", fail_count); end
    if (error !== 1'b1) begin failures++; $display("[TB] FAIL corr_error got %b want 1", error); end
`ifdef AES_CHECK_CAPTURE_EN
    if (cap_valid !== 1'b1) begin failures++; $display("[TB] FAIL cap_valid got %b want 1", cap_valid); end
    if (cap_index !== 16'd1) begin failures++; $display("[TB] FAIL cap_index got %0d want 1", cap_index); end
    if (cap_expected !== FIPS1) begin failures++; $display("[TB] FAIL cap_expected got %h want %h", cap_expected, FIPS1); end
    if (cap_actual !== (FIPS1 ^ 128'd1)) begin failures++; $display("[TB] FAIL cap_actual got %h want %h", cap_actual, FIPS1 ^ 128'd1); end
`else
    if (cap_valid !== 1'b0) begin failures++; $display("[TB] FAIL cap_valid got %b want 0", cap_valid); end
    if (cap_index !== 16'd0) begin failures++; $display("[TB] FAIL cap_index got %0d want 0", cap_index); end
    if (cap_expected !== '0) begin failures++; $display("[TB] FAIL cap_expected got %h want 0", cap_expected); end
    if (cap_actual !== '0) begin failures++; $display("[TB] FAIL cap_actual got %h want 0", cap_actual); end
`endif
  endtask

  task automatic test_mask();
    push('0, {120'd0, 8'd0} | 128'hFF00, 128'hFF);
    idle_cycles(LAT + 1);
    checks++;
    if (chk_pass !== 1'b1) begin failures++; $display("[TB] FAIL mask_ff00 got %b want 1", chk_pass); end
    push('0, 128'h0001, 128'hFF);
    idle_cycles(LAT + 1);
    checks += 3;
    if (chk_pass !== 1'b0) begin failures++; $display("[TB] FAIL mask_0001 got %b want 0", chk_pass); end
    if (fail_count !== 16'd2) begin failures++; $display("[TB] FAIL mask_fail_count got %0d want 2", fail_count); end
`ifdef AES_CHECK_CAPTURE_EN
    if (cap_index !== 16'd1) begin failures++; $display("[TB] FAIL cap_keep got %0d want 1", cap_index); end
`else
    if (cap_index !== 16'd0) begin failures++; $display("[TB] FAIL cap_keep got %0d want 0", cap_index); end
`endif
  endtask

  task automatic test_clear_flight();
    do_clear();
    push(FIPS0, ONES, FIPS0);
    push(FIPS1, ONES, FIPS1);
    push(FIPS0, ONES, FIPS0);
    idle_cycles(5);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_expected = FIPS1; in_mask = ONES;
    sb.delete();
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (idle !== 1'b1) begin failures++; $display("[TB] FAIL clear_idle got %b want 1", idle); end
    idle_cycles(LAT + 5);
    checks += 4;
    if (pulses !== 0) begin failures++; $display("[TB] FAIL clear_pulses got %0d want 0", pulses); end
    if (pass_count !== 16'd0) begin failures++; $display("[TB] FAIL clear_pass_count got %0d want 0", pass_count); end
    if (fail_count !== 16'd0) begin failures++; $display("[TB] FAIL clear_fail_count got %0d want 0", fail_count); end
    if (error !== 1'b0 || cap_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_error got %b/%b want 0/0", error, cap_valid); end
  endtask

  task automatic test_back_to_back();
    int np = 0, nf = 0;
    do_clear();
    for (int i = 0; i < 40; i++) begin
      logic [127:0] e, m, a;
      e = {$urandom, $urandom, $urandom, $urandom};
      m = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom, $urandom} : ONES;
      a = ($urandom_range(0, 2) == 0) ? (e ^ (128'd1 << $urandom_range(0, 127))) : e;
      if (((a ^ e) & m) == '0) np++; else nf++;
      push(e, m, a);
    end
    idle_cycles(LAT + 3);
    checks += 4;
    if (pulses !== 40) begin failures++; $display("[TB] FAIL b2b_pulses got %0d want 40", pulses); end
    else if (pulse_edges[39] - pulse_edges[0] != 39) begin failures++; $display("[TB] FAIL b2b_spacing got %0d want 39", pulse_edges[39] - pulse_edges[0]); end
    if (pass_count !== 16'(np)) begin failures++; $display("[TB] FAIL b2b_pass_count got %0d want %0d", pass_count, np); end
    if (fail_count !== 16'(nf)) begin failures++; $display("[TB] FAIL b2b_fail_count got %0d want %0d", fail_count, nf); end
    if (error !== (nf != 0)) begin failures++; $display("[TB] FAIL b2b_error got %b want %b", error, nf != 0); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) push2(FIPS0 + 128'(i), FIPS0 + 128'(i));
    idle_cycles(LAT2 + 3);
    checks += 3;
    if (pulses2 !== 5) begin failures++; $display("[TB] FAIL sat_pulses got %0d want 5", pulses2); end
    if (pass_count2 !== 2'd3) begin failures++; $display("[TB] FAIL sat_pass_count got %0d want 3", pass_count2); end
    if (error2 !== 1'b0) begin failures++; $display("[TB] FAIL sat_error got %b want 0", error2); end
    for (int i = 0; i < 4; i++) push2(FIPS1, ~FIPS1);
    idle_cycles(LAT2 + 3);
    checks += 3;
    if (pulses2 !== 9) begin failures++; $display("[TB] FAIL sat_fail_pulses got %0d want 9", pulses2); end
    if (fail_count2 !== 2'd3) begin failures++; $display("[TB] FAIL sat_fail_count got %0d want 3", fail_count2); end
    if (error2 !== 1'b1) begin failures++; $display("[TB] FAIL sat_error_fail got %b want 1", error2); end
  endtask

  task automatic test_async_reset();
    int p0;
    push(FIPS0, ONES, FIPS1);
    push(FIPS1, ONES, FIPS1);
    push(FIPS0, ONES, FIPS0);
    idle_cycles(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (idle !== 1'b1) begin failures++; $display("[TB] FAIL arst_idle got %b want 1", idle); end
    if (chk_valid !== 1'b0 || chk_pass !== 1'b0) begin failures++; $display("[TB] FAIL arst_chk got %b/%b want 0/0", chk_valid, chk_pass); end
    if (pass_count !== 16'd0) begin failures++; $display("[TB] FAIL arst_pass_count got %0d want 0", pass_count); end
    if (fail_count !== 16'd0) begin failures++; $display("[TB] FAIL arst_fail_count got %0d want 0", fail_count); end
    if (error !== 1'b0 || error2 !== 1'b0) begin failures++; $display("[TB] FAIL arst_error got %b/%b want 0/0", error, error2); end
    if (cap_valid !== 1'b0 || pass_count2 !== 2'd0) begin failures++; $display("[TB] FAIL arst_misc got %b/%0d want 0/0", cap_valid, pass_count2); end
    sb.delete();
    p0 = pulses;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(LAT + 5);
    checks++;
    if (pulses !== p0) begin failures++; $display("[TB] FAIL arst_pulses got %0d want %0d", pulses - p0, 0); end
  endtask

  initial begin
    test_reset();
    test_fips_stream();
    test_corruption();
    test_mask();
    test_clear_flight();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_stream_checker.md
# aes_stream_checker

Parametrised, latency-aligned output checker for pipelined block-cipher cores such as aes_128. Each expected result is pushed in alongside its plaintext/key. The block delays it through an internal LATENCY-deep valid/data pipeline and compares it against the core output exactly LATENCY cycles later. It keeps pass/fail counts and a sticky error flag so long regressions and on-chip self-test need no hand-timed checks.

## Interface
- DATA_W, 128: width of expected and actual data.
- LATENCY, 21: core latency in cycles from input sample to valid output; legal range 1..255.
- CNT_W, 16: width of pass and fail counters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clear  in  1  synchronous flush of pipeline, counters, error and capture.
- in_valid  in  1  expected entry present this cycle.
- in_expected  in  DATA_W  expected core output for the input launched this cycle.
- in_mask  in  DATA_W  per-bit compare enable (1 = compare), travels with the entry.
- dut_out  in  DATA_W  core output.
- chk_valid  out  1  one-cycle pulse: a comparison completed.
- chk_pass  out  1  result of that comparison; qualified by chk_valid.
- pass_count  out  CNT_W  saturating count of passes.
- fail_count  out  CNT_W  saturating count of failures.
- error  out  1  sticky: at least one failure since reset or clear.
- idle  out  1  no entries in flight.
- cap_valid  out  1  first-failure capture holds data.
- cap_expected  out  DATA_W  expected value of first failure.
- cap_actual  out  DATA_W  dut_out of first failure.
- cap_index  out  CNT_W  pass_count+fail_count at the first failure, i.e. its 0-based result index.

## Operation
- Pipeline: LATENCY stages, each holding {valid, expected, mask}. An entry enters at the edge where in_valid=1 and exits LATENCY edges later.
- Compare at exit: pass when ((dut_out ^ expected) & mask) == 0. An all-zero mask always passes.
- On exit: chk_valid=1 and chk_pass=result. The matching counter increments, saturating at 2^CNT_W-1. A failure sets error.
- No exit: chk_valid=0. chk_pass holds its last value. Counters hold.
- idle=1 when all stage valid bits are 0.
- clear=1: all stage valid bits are zeroed, counters go to 0, error and cap_valid go to 0. An in_valid asserted in the same cycle is dropped. An entry exiting that cycle is discarded and not counted.
- Back-to-back in_valid every cycle is supported indefinitely, giving one comparison per cycle at steady state.
- dut_out is ignored on cycles with no exiting entry.

## Timing
- Reset values: chk_valid=0, chk_pass=0, pass_count=0, fail_count=0, error=0, idle=1, cap_valid=0, cap_expected=0, cap_actual=0, cap_index=0. All stage valid bits are 0.
- in_valid sampled at edge k means dut_out is sampled at edge k+LATENCY. chk_valid, chk_pass, the counters and error are registered at edge k+LATENCY and visible the following cycle.
- idle falls after the edge sampling in_valid. It rises after the edge at which the last entry exits.
- Reset mid-operation: all in-flight entries are lost and outputs take their reset values immediately. No comparison is reported for the lost entries.
- Saturated counter plus another event of the same kind: the counter holds at max. error and chk_valid still behave normally.

## Configuration
- AES_CHECK_CAPTURE_EN defined:
  - On the first failure after reset or clear, the block registers cap_expected, cap_actual and cap_index, and sets cap_valid at the same edge the failure is counted.
  - Later failures do not overwrite the capture.
- AES_CHECK_CAPTURE_EN undefined:
  - The capture registers are not built.
  - cap_valid, cap_expected, cap_actual and cap_index are tied to 0.
  - All other behaviour is identical.

## Test plan
- FIPS-197 stream (LATENCY=21), in_mask all-ones:
  - Push expected 3925841d02dc09fbdc118597196a0b32, then 69c4e0d86a7b0430d8cdb78070b4c55a, on consecutive cycles.
  - Drive dut_out with those values 21 cycles later.
  - Required: two chk_valid pulses on consecutive cycles, chk_pass=1 both times, pass_count=2, error=0, idle=1 afterwards.
- Single-bit corruption: as above, but with the second dut_out bit 0 flipped.
  - Required: pass_count=1, fail_count=1, error=1.
  - With the macro defined: cap_index=1, cap_expected=69c4...c55a, cap_actual=69c4...c55b.
- Mask: expected 0, dut_out 0xFF, mask 0x...FF00.
  - Required: chk_pass=1.
  - Same stimulus with mask 0x...0001: chk_pass=0.
- Clear during flight:
  - Push 3 entries, then assert clear 5 cycles later while also asserting in_valid.
  - Required: no chk_valid pulses ever appear, counters stay 0, idle=1 from the cycle after clear.
- Saturation with CNT_W=2: push 5 passing entries.
  - Required: pass_count sticks at 3 and five chk_valid pulses are seen.
- Async reset mid-stream:
  - Drop rst_n between edges while entries are in flight.
  - Required: all outputs take their reset values immediately, and no chk_valid pulse follows after release.
